spi_master: RTL
===============

Name: spi_master

Overview:
- Byte-wide SPI master engine; the far end of the load/store unit's SPI register interface.
- Consumes the one-cycle spi_trigger pulse and spi_command byte, and shifts the byte out MSB-first on the SPI pins.
- Simultaneously shifts in the response byte, and returns it on spi_response together with a busy flag on spi_csr[0].
- Sits between the load/store unit and the board SPI pins (flash/peripherals).

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; legal range 2..255.
DATA_W, 8, bits per transfer; fixed at 8 for this interface.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
spi_trigger  input  1  one-cycle start pulse from the load/store unit
spi_command  input  8  byte to transmit; sampled on the accepting edge
spi_response  output  8  last received byte; held until the next completion
spi_csr  inout  8  drives bit 0 (BUSY) only; bits 7:1 are high-Z from this block and read as configuration
spi_sclk  output  1  SPI clock
spi_mosi  output  1  master out
spi_miso  input  1  master in
spi_cs_n  output  1  chip select; registered copy of spi_csr[2]

Behaviour:
- Reset is asynchronous, active-low: the 'Already decided' requirement for this block.
- spi_csr map: [0] BUSY (driven here), [1] CPOL, [2] CS level, [3] CPHA, [7:4] reserved/ignored.
- Reset values: state IDLE, BUSY=0, spi_response=8'h00, spi_sclk=0, spi_mosi=0, spi_cs_n=1, divider counter=0, bit counter=0.
- spi_cs_n <= spi_csr[2] every clk edge (one cycle of latency). It is fully software-owned; the engine never toggles CS itself.
- In IDLE, spi_sclk <= spi_csr[1] (tracks CPOL).
- States: IDLE, SHIFT.
- IDLE -> SHIFT on a clk edge with spi_trigger=1. On that same edge:
  - tx shift reg <= spi_command
  - CPOL/CPHA are latched; later csr changes do not affect the running transfer
  - BUSY <= 1, divider=0, edge counter=0
  - if CPHA=0: spi_mosi <= spi_command[7]
- SHIFT: divider counts 0..CLK_DIV-1. At wrap, spi_sclk toggles and the edge counter increments (16 edges per byte).
  - Leading edges (odd edge numbers 1,3,..,15): if CPHA=0, sample spi_miso into rx LSB; if CPHA=1, drive the next tx bit on spi_mosi.
  - Trailing edges (2,4,..,16): if CPHA=0, drive the next tx bit (skip after edge 16); if CPHA=1, sample spi_miso.
- Completion, on the edge-16 clk edge:
  - state <= IDLE, BUSY <= 0
  - spi_response <= full received byte (includes the bit sampled at that edge for CPHA=1)
  - spi_mosi holds its last value
- BUSY timing: high for exactly 16*CLK_DIV clk cycles, starting the cycle after the accepting edge.
- spi_trigger while BUSY=1: ignored (no queue unless the feature below is enabled). spi_response is unchanged.
- spi_trigger on the same edge as completion: treated as busy, so ignored (without the feature).
- Reset asserted mid-transfer: immediately returns to reset values. The partial byte is discarded; spi_response reads 8'h00.
- spi_miso is sampled directly (no synchronizer); the SCLK period guarantees ≥ 2 clk cycles of setup.

Optional Feature:
- Macro SPI_CMD_QUEUE_EN.
- Defined: a one-entry command holding register.
  - A trigger while BUSY (including the completion edge) stores spi_command and sets pending.
  - On completion with pending=1, the engine re-enters SHIFT on that same edge with the held byte. BUSY stays 1 continuously and pending clears.
  - Further triggers while pending=1 are dropped.
  - spi_response still updates at each byte completion.
- Not defined: triggers while BUSY are ignored, as above; no holding register is synthesized.

Decomposition:
- Package spi_pkg holds:
  - csr bit-index constants SPI_CSR_BUSY=0, SPI_CSR_CPOL=1, SPI_CSR_CS=2, SPI_CSR_CPHA=3
  - the state enum spi_state_t {SPI_IDLE, SPI_SHIFT}
- One sub-module is natural: spi_clk_gen. It holds the CLK_DIV divider and edge counter, and outputs lead_edge/trail_edge strobes and last_edge.

Test Plan:
- Mode 0, CLK_DIV=4, MISO looped to MOSI: trigger with 0xA5 -> BUSY high exactly 64 cycles, 8 rising SCLK edges, spi_response=0xA5, final SCLK=0.
- Mode 3 (csr=0x0A), MISO driven by a slave model returning 0x3C, command 0x81 -> MOSI bits 1,0,0,0,0,0,0,1 valid on rising edges, spi_response=0x3C, idle SCLK=1.
- CS control: write csr bit2 1->0->1 -> spi_cs_n follows one cycle later; no SCLK activity without a trigger.
- Trigger 0x55 at cycle 10 of a running 0xA5 transfer (feature off) -> only 0xA5 shifted, spi_response=0xA5. With SPI_CMD_QUEUE_EN: 0x55 follows back-to-back, BUSY high for 128 cycles, final spi_response=0x55.
- rst_n low at edge 7 of a transfer -> BUSY=0, spi_sclk=0, spi_cs_n=1, spi_response=0x00 within the same cycle. A new trigger after release completes normally.
- CPOL changed from 0 to 1 mid-transfer -> transfer completes with the latched CPOL=0; SCLK returns to 1 only after BUSY falls.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared constants and state type for the SPI master engine.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // spi_csr bit map; bits 7:4 are reserved
    localparam int SPI_CSR_BUSY = 0;
    localparam int SPI_CSR_CPOL = 1;
    localparam int SPI_CSR_CS   = 2;
    localparam int SPI_CSR_CPHA = 3;

    localparam int SPI_EDGE_W    = 4;
    localparam int SPI_LAST_EDGE = 15;

    typedef enum logic [0:0] {
        SPI_IDLE  = 1'b0,
        SPI_SHIFT = 1'b1
    } spi_state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_if
// Description : Load/store-side register signals plus board SPI pins.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_if;

    logic       spi_trigger;
    logic [7:0] spi_command;
    logic [7:0] spi_response;
    wire  [7:0] spi_csr;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_cs_n;

    // master: the SPI engine itself; slave: the load/store unit and board side
    modport master (
        input  spi_trigger, spi_command, spi_miso,
        output spi_response, spi_sclk, spi_mosi, spi_cs_n,
        inout  spi_csr
    );

    modport slave (
        output spi_trigger, spi_command, spi_miso,
        input  spi_response, spi_sclk, spi_mosi, spi_cs_n,
        inout  spi_csr
    );

endinterface : spi_if
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_gen
// Description : SCLK half-period divider and edge counter (16 edges per byte).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  run_i,
    input  wire  start_i,
    output logic lead_edge_o,
    output logic trail_edge_o,
    output logic last_edge_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("spi_clk_gen: CLK_DIV must be within 2..255");
    end

    logic [DIV_W-1:0]      div_q;
    logic [SPI_EDGE_W-1:0] edge_q;
    logic                  w_wrap;

    assign w_wrap = run_i && (div_q == DIV_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            edge_q <= '0;
        end else if (start_i) begin
            div_q  <= '0;
            edge_q <= '0;
        end else if (w_wrap) begin
            div_q  <= '0;
            edge_q <= edge_q + 1'b1;
        end else if (run_i) begin
            div_q  <= div_q + 1'b1;
        end
    end

    // edge_q holds the number of edges already produced, so an even count
    // means the edge about to fire is a leading (odd-numbered) one
    assign lead_edge_o  = w_wrap && !edge_q[0];
    assign trail_edge_o = w_wrap &&  edge_q[0];
    assign last_edge_o  = w_wrap && (edge_q == SPI_EDGE_W'(SPI_LAST_EDGE));

endmodule : spi_clk_gen
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : Byte-wide SPI master, MSB first, CPOL/CPHA from spi_csr.
//               Build option SPI_CMD_QUEUE_EN adds a one-entry command holder.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input wire    clk,
    input wire    rst_n,
    spi_if.master bus
);

    if (DATA_W != 8) begin : g_bad_data_w
        $error("spi_master: DATA_W is fixed at 8");
    end

    spi_state_t        state_q;
    logic              busy_q;
    logic [DATA_W-1:0] resp_q;
    logic              sclk_q;
    logic              mosi_q;
    logic              cs_n_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic              cpol_q;
    logic              cpha_q;

    logic              w_lead;
    logic              w_trail;
    logic              w_last;
    logic              w_accept;
    logic              w_restart;
    logic [DATA_W-1:0] w_next_cmd;
    logic [DATA_W-1:0] w_rx_shift;

    assign w_accept   = (state_q == SPI_IDLE) && bus.spi_trigger;
    assign w_rx_shift = {rx_q[DATA_W-2:0], bus.spi_miso};

`ifdef SPI_CMD_QUEUE_EN
    logic              pend_q;
    logic [DATA_W-1:0] hold_q;

    // a trigger landing on the completion edge itself restarts directly
    assign w_restart  = w_last && (pend_q || bus.spi_trigger);
    assign w_next_cmd = pend_q ? hold_q : bus.spi_command;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            hold_q <= '0;
        end else if (w_restart) begin
            pend_q <= 1'b0;
        end else if ((state_q == SPI_SHIFT) && bus.spi_trigger && !pend_q) begin
            pend_q <= 1'b1;
            hold_q <= bus.spi_command;
        end
    end
`else
    assign w_restart  = 1'b0;
    assign w_next_cmd = bus.spi_command;
`endif

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (state_q == SPI_SHIFT),
        .start_i      (w_accept || w_restart),
        .lead_edge_o  (w_lead),
        .trail_edge_o (w_trail),
        .last_edge_o  (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SPI_IDLE;
            busy_q  <= 1'b0;
            resp_q  <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            tx_q    <= '0;
            rx_q    <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
        end else begin
            cs_n_q <= bus.spi_csr[SPI_CSR_CS];
            case (state_q)
                SPI_IDLE: begin
                    sclk_q <= bus.spi_csr[SPI_CSR_CPOL];
                    if (bus.spi_trigger) begin
                        state_q <= SPI_SHIFT;
                        busy_q  <= 1'b1;
                        tx_q    <= bus.spi_command;
                        rx_q    <= '0;
                        cpol_q  <= bus.spi_csr[SPI_CSR_CPOL];
                        cpha_q  <= bus.spi_csr[SPI_CSR_CPHA];
                        if (!bus.spi_csr[SPI_CSR_CPHA]) begin
                            mosi_q <= bus.spi_command[DATA_W-1];
                        end
                    end
                end
                SPI_SHIFT: begin
                    if (w_lead || w_trail) begin
                        sclk_q <= ~sclk_q;
                    end
                    if (w_lead) begin
                        if (!cpha_q) begin
                            rx_q <= w_rx_shift;
                        end else begin
                            mosi_q <= tx_q[DATA_W-1];
                            tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    if (w_trail) begin
                        if (cpha_q) begin
                            rx_q <= w_rx_shift;
                        end else if (!w_last) begin
                            mosi_q <= tx_q[DATA_W-2];
                            tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    // CPHA=1 takes its final bit on this very edge
                    if (w_last) begin
                        resp_q <= cpha_q ? w_rx_shift : rx_q;
                        if (w_restart) begin
                            tx_q <= w_next_cmd;
                            rx_q <= '0;
                            if (!cpha_q) begin
                                mosi_q <= w_next_cmd[DATA_W-1];
                            end
                        end else begin
                            state_q <= SPI_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= SPI_IDLE;
            endcase
        end
    end

    assign bus.spi_csr[SPI_CSR_BUSY] = busy_q;
    assign bus.spi_response          = resp_q;
    assign bus.spi_sclk              = sclk_q;
    assign bus.spi_mosi              = mosi_q;
    assign bus.spi_cs_n              = cs_n_q;

endmodule : spi_master
`default_nettype wire
